// File: rtl/arq_pkg.sv
// Shared definitions for the ARQ receiver: response encodings, header marker,
// FSM state type and datapath widths.
package arq_pkg;

  localparam int SEQ_W  = 12;
  localparam int DATA_W = 16;

  localparam logic [3:0] HDR_MARKER = 4'hA;

  typedef enum logic [1:0] {
    RSP_NONE = 2'b00,
    RSP_NAK  = 2'b01,
    RSP_ACK  = 2'b10
  } ackNak_e;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    RESP
  } rxState_e;

endpackage

// File: rtl/arq_rx_timer.sv
// Inactivity counter: counts enabled cycles since the last clear and
// saturates at TIMEOUT_CYC, where it flags expiry.
module arq_rx_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == CNT_W'(TIMEOUT_CYC));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/arq_receiver.sv
// Go-back ARQ receiver: parses {header, payload, checksum} frames, answers
// ACK/NAK with a sequence number and hands accepted payloads to a one-entry buffer.
module arq_receiver
  import arq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              dn_busy_n,
  output logic [1:0]        ack_nak,
  output logic [SEQ_W-1:0]  ack_seq,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              frame_err
);

  rxState_e          state_q, state_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [SEQ_W-1:0]  expSeq_q, expSeq_d;
  ackNak_e           ackNak_q, ackNak_d;
  logic [SEQ_W-1:0]  ackSeq_q, ackSeq_d;
  logic              outValid_q, outValid_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic              frameErr_q, frameErr_d;

  logic              inFrame;
  logic              timerExpired;
  logic              drain;
  logic              bufFree;
  logic              load;
  logic [SEQ_W-1:0]  expSeqPrev;
  logic [DATA_W-1:0] expChecksum;

  assign inFrame     = (state_q == PAYLOAD) || (state_q == CHECK);
  assign drain       = outValid_q && dn_busy_n;
  assign bufFree     = !outValid_q || drain;
  assign expSeqPrev  = expSeq_q - SEQ_W'(1);
  assign expChecksum = {HDR_MARKER, seq_q} ^ payload_q;

  arq_rx_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (rx_valid || !inFrame),
    .enable (inFrame),
    .expired(timerExpired)
  );

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    payload_d  = payload_q;
    expSeq_d   = expSeq_q;
    ackNak_d   = RSP_NONE;
    ackSeq_d   = ackSeq_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    frameErr_d = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      // RESP behaves like IDLE so a new header can follow a checksum immediately.
      IDLE, RESP: begin
        state_d = IDLE;
        if (rx_valid) begin
          if (rx_data[DATA_W-1:SEQ_W] == HDR_MARKER) begin
            seq_d   = rx_data[SEQ_W-1:0];
            state_d = PAYLOAD;
          end else begin
            frameErr_d = 1'b1;
          end
        end
      end

      PAYLOAD: begin
        if (rx_valid) begin
          payload_d = rx_data;
          state_d   = CHECK;
        end else if (timerExpired) begin
          state_d    = IDLE;
          frameErr_d = 1'b1;
        end
      end

      CHECK: begin
        if (rx_valid) begin
          state_d  = RESP;
          ackNak_d = RSP_NAK;
          ackSeq_d = expSeq_q;
          if (rx_data == expChecksum) begin
            if (seq_q == expSeq_q) begin
              if (bufFree) begin
                ackNak_d = RSP_ACK;
                ackSeq_d = seq_q;
                load     = 1'b1;
                expSeq_d = expSeq_q + SEQ_W'(1);
              end
            end else if (seq_q == expSeqPrev) begin
              ackNak_d = RSP_ACK;
              ackSeq_d = seq_q;
            end
          end
        end else if (timerExpired) begin
          state_d    = IDLE;
          frameErr_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // A load in the same cycle as a drain wins, keeping out_valid high.
    if (load) begin
      outValid_d = 1'b1;
      outData_d  = payload_q;
    end else if (drain) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      payload_q  <= '0;
      expSeq_q   <= '0;
      ackNak_q   <= RSP_NONE;
      ackSeq_q   <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      payload_q  <= payload_d;
      expSeq_q   <= expSeq_d;
      ackNak_q   <= ackNak_d;
      ackSeq_q   <= ackSeq_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      frameErr_q <= frameErr_d;
    end
  end

  assign ack_nak   = ackNak_q;
  assign ack_seq   = ackSeq_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign frame_err = frameErr_q;

endmodule

// File: tb/tb_arq_receiver.sv
// Directed self-checking bench for arq_receiver with hand-computed frames
// and expected responses.
module tb_arq_receiver;

  logic        clk       = 1'b0;
  logic        reset_n   = 1'b0;
  logic        rx_valid  = 1'b0;
  logic [15:0] rx_data   = '0;
  logic        dn_busy_n = 1'b1;
  logic [1:0]  ack_nak;
  logic [11:0] ack_seq;
  logic        out_valid;
  logic [15:0] out_data;
  logic        frame_err;

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          xferCount   = 0;
  logic [15:0] lastXfer    = '0;

  arq_receiver #(.TIMEOUT_CYC(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .dn_busy_n(dn_busy_n),
    .ack_nak  (ack_nak),
    .ack_seq  (ack_seq),
    .out_valid(out_valid),
    .out_data (out_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Counts downstream transfers: a handshake visible at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (reset_n && out_valid && dn_busy_n) begin
      xferCount = xferCount + 1;
      lastXfer  = out_data;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun = testsRun + 1;
    if (observed !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data);
    rx_valid = valid;
    rx_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [15:0] hdr, input logic [15:0] pay, input logic [15:0] chk);
    applyStimulus(1'b1, hdr);
    applyStimulus(1'b1, pay);
    applyStimulus(1'b1, chk);
    rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          xferBase;
    int          errPulses;
    int          ackSeen;
    int          bulkMiss;
    logic [15:0] hdr;
    logic [15:0] pay;

    #12;
    checkOutput("rst_ack_nak", 32'(ack_nak), 32'h0);
    checkOutput("rst_ack_seq", 32'(ack_seq), 32'h0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idleCycles(2);

    sendFrame(16'hA000, 16'h1234, 16'hB235);
    checkOutput("badsum_ack_nak", 32'(ack_nak), 32'h1);
    checkOutput("badsum_ack_seq", 32'(ack_seq), 32'h000);
    checkOutput("badsum_out_valid", 32'(out_valid), 32'h0);
    idleCycles(2);

    xferBase = xferCount;
    sendFrame(16'hA000, 16'h1234, 16'hB234);
    checkOutput("good0_ack_nak", 32'(ack_nak), 32'h2);
    checkOutput("good0_ack_seq", 32'(ack_seq), 32'h000);
    checkOutput("good0_out_valid", 32'(out_valid), 32'h1);
    checkOutput("good0_out_data", 32'(out_data), 32'h1234);
    idleCycles(3);
    checkOutput("good0_resp_clear", 32'(ack_nak), 32'h0);
    checkOutput("good0_drained", 32'(out_valid), 32'h0);
    checkOutput("good0_xfers", 32'(xferCount - xferBase), 32'd1);
    checkOutput("good0_xfer_data", 32'(lastXfer), 32'h1234);

    xferBase = xferCount;
    sendFrame(16'hA000, 16'h1234, 16'hB234);
    checkOutput("dup0_ack_nak", 32'(ack_nak), 32'h2);
    checkOutput("dup0_ack_seq", 32'(ack_seq), 32'h000);
    checkOutput("dup0_out_valid", 32'(out_valid), 32'h0);
    idleCycles(3);
    checkOutput("dup0_xfers", 32'(xferCount - xferBase), 32'd0);

    sendFrame(16'hA005, 16'h1234, 16'hB231);
    checkOutput("seq5_ack_nak", 32'(ack_nak), 32'h1);
    checkOutput("seq5_ack_seq", 32'(ack_seq), 32'h001);
    idleCycles(1);

    sendFrame(16'hA001, 16'h0BEE, 16'hABEF);
    checkOutput("seq1_ack_nak", 32'(ack_nak), 32'h2);
    checkOutput("seq1_ack_seq", 32'(ack_seq), 32'h001);
    checkOutput("seq1_out_data", 32'(out_data), 32'h0BEE);
    idleCycles(3);

    dn_busy_n = 1'b0;
    xferBase  = xferCount;
    sendFrame(16'hA002, 16'h1111, 16'hB113);
    checkOutput("busy2_ack_nak", 32'(ack_nak), 32'h2);
    checkOutput("busy2_ack_seq", 32'(ack_seq), 32'h002);
    checkOutput("busy2_out_data", 32'(out_data), 32'h1111);
    idleCycles(1);
    sendFrame(16'hA003, 16'h2222, 16'h8221);
    checkOutput("busy3_ack_nak", 32'(ack_nak), 32'h1);
    checkOutput("busy3_ack_seq", 32'(ack_seq), 32'h003);
    checkOutput("busy3_held_valid", 32'(out_valid), 32'h1);
    checkOutput("busy3_held_data", 32'(out_data), 32'h1111);
    checkOutput("busy_no_xfer", 32'(xferCount - xferBase), 32'd0);
    dn_busy_n = 1'b1;
    idleCycles(3);
    checkOutput("busy_release_xfers", 32'(xferCount - xferBase), 32'd1);
    checkOutput("busy_release_data", 32'(lastXfer), 32'h1111);
    checkOutput("busy_release_valid", 32'(out_valid), 32'h0);

    dn_busy_n = 1'b0;
    xferBase  = xferCount;
    sendFrame(16'hA003, 16'h3333, 16'h9330);
    checkOutput("seq3_ack_nak", 32'(ack_nak), 32'h2);
    applyStimulus(1'b1, 16'hA004);
    applyStimulus(1'b1, 16'h4444);
    dn_busy_n = 1'b1;
    applyStimulus(1'b1, 16'hE440);
    rx_valid = 1'b0;
    checkOutput("drainload_ack_nak", 32'(ack_nak), 32'h2);
    checkOutput("drainload_ack_seq", 32'(ack_seq), 32'h004);
    checkOutput("drainload_valid", 32'(out_valid), 32'h1);
    checkOutput("drainload_data", 32'(out_data), 32'h4444);
    checkOutput("drainload_prev_xfer", 32'(lastXfer), 32'h3333);
    idleCycles(3);
    checkOutput("drainload_xfers", 32'(xferCount - xferBase), 32'd2);

    xferBase = xferCount;
    sendFrame(16'hA005, 16'h0055, 16'hA050);
    checkOutput("b2b5_ack_seq", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'h005}));
    sendFrame(16'hA006, 16'h0066, 16'hA060);
    checkOutput("b2b6_ack_seq", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'h006}));
    idleCycles(3);
    checkOutput("b2b_xfers", 32'(xferCount - xferBase), 32'd2);
    checkOutput("b2b_last_data", 32'(lastXfer), 32'h0066);

    applyStimulus(1'b1, 16'hA7FF);
    rx_valid  = 1'b0;
    errPulses = 0;
    ackSeen   = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_err === 1'b1) errPulses = errPulses + 1;
      if (ack_nak !== 2'b00) ackSeen = ackSeen + 1;
    end
    checkOutput("timeout_err_pulses", 32'(errPulses), 32'd1);
    checkOutput("timeout_no_ack", 32'(ackSeen), 32'd0);

    applyStimulus(1'b1, 16'h5000);
    rx_valid = 1'b0;
    checkOutput("badhdr_err", 32'(frame_err), 32'h1);
    idleCycles(1);
    checkOutput("badhdr_err_clear", 32'(frame_err), 32'h0);
    sendFrame(16'hA007, 16'h0777, 16'hA770);
    checkOutput("after_err_seq7", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'h007}));
    idleCycles(2);

    applyStimulus(1'b1, 16'hA008);
    idleCycles(10);
    applyStimulus(1'b1, 16'h0888);
    idleCycles(10);
    applyStimulus(1'b1, 16'hA880);
    rx_valid = 1'b0;
    checkOutput("gapped_seq8", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'h008}));
    idleCycles(2);

    reset_n = 1'b0;
    idleCycles(1);
    reset_n  = 1'b1;
    bulkMiss = 0;
    for (int s = 0; s < 4095; s++) begin
      hdr = {4'hA, 12'(s)};
      pay = 16'(s * 3);
      sendFrame(hdr, pay, hdr ^ pay);
      if (ack_nak !== 2'b10 || ack_seq !== 12'(s)) bulkMiss = bulkMiss + 1;
    end
    checkOutput("bulk_ack_misses", 32'(bulkMiss), 32'd0);
    idleCycles(2);
    sendFrame(16'hAFFF, 16'h0F0F, 16'hA0F0);
    checkOutput("seqFFF_ack", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'hFFF}));
    idleCycles(2);
    xferBase = xferCount;
    sendFrame(16'hAFFF, 16'h0F0F, 16'hA0F0);
    checkOutput("dupFFF_ack", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'hFFF}));
    idleCycles(2);
    checkOutput("dupFFF_no_xfer", 32'(xferCount - xferBase), 32'd0);

    dn_busy_n = 1'b0;
    sendFrame(16'hA000, 16'hCAFE, 16'h6AFE);
    checkOutput("wrap000_ack", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'h000}));
    idleCycles(1);
    applyStimulus(1'b1, 16'hA001);
    applyStimulus(1'b1, 16'h5555);
    rx_valid = 1'b0;
    checkOutput("prereset_valid", 32'(out_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_outputs", 32'({ack_nak, ack_seq, out_valid, frame_err}), 32'h0);
    checkOutput("midreset_out_data", 32'(out_data), 32'h0);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    dn_busy_n = 1'b1;
    idleCycles(1);
    sendFrame(16'hA000, 16'h1234, 16'hB234);
    checkOutput("postreset_seq0", 32'({ack_nak, ack_seq}), 32'({2'b10, 12'h000}));
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/arq_receiver.md
ARQ_RECEIVER -- requirements
Module: arq_receiver

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: idle cycles allowed between words of one frame before abort.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rx_valid  input  1  rx_data carries a channel word this cycle.
REQ-005 rx_data  input  16  channel word from the upstream transmitter's dout.
REQ-006 dn_busy_n  input  1  downstream ready; low = busy, high = accepts out_data.
REQ-007 ack_nak  output  2  response to transmitter: 00 none, 10 ACK, 01 NAK, 11 unused.
REQ-008 ack_seq  output  12  sequence number qualified by a nonzero ack_nak.
REQ-009 out_valid  output  1  out_data holds a delivered payload.
REQ-010 out_data  output  16  payload word to downstream.
REQ-011 frame_err  output  1  one-cycle pulse on header-marker error or inter-word timeout.

Function
REQ-012 Frame is three words: header {4'hA, seq[11:0]}, payload, checksum = header XOR payload.
REQ-013 FSM states: IDLE (await header), PAYLOAD, CHECK, RESP; a word is accepted on any cycle with rx_valid=1.
REQ-014 IDLE: header with marker != 4'hA is discarded, frame_err pulses next cycle, state stays IDLE.
REQ-015 IDLE -> PAYLOAD on good header; PAYLOAD -> CHECK on next word; CHECK -> RESP on next word; RESP -> IDLE after one cycle.
REQ-016 rx_valid low between words is legal; inactivity counter clears on each accepted word.
REQ-017 Counter reaching TIMEOUT_CYC in PAYLOAD or CHECK: return to IDLE, frame discarded, no ack_nak, frame_err pulses one cycle.
REQ-018 Evaluation in the cycle the checksum word is accepted; ack_nak/ack_seq are registered and valid exactly one cycle later (the RESP cycle), 00 otherwise.
REQ-019 Checksum mismatch: NAK, ack_seq = expected seq; nothing delivered; expected unchanged.
REQ-020 Good checksum, seq == expected, buffer free: ACK with ack_seq = seq, payload loaded into buffer, expected increments.
REQ-021 Good checksum, seq == expected, buffer occupied: NAK with ack_seq = expected; payload dropped.
REQ-022 Good checksum, seq == expected-1 (mod 4096, duplicate): ACK with ack_seq = seq; payload not delivered; expected unchanged.
REQ-023 Good checksum, any other seq: NAK with ack_seq = expected.
REQ-024 Expected seq wraps 12'hFFF -> 12'h000; duplicate of expected 12'h000 is 12'hFFF.
REQ-025 One-entry output buffer: out_valid rises the cycle after load, holds out_data stable until a cycle with out_valid=1 and dn_busy_n=1, then clears next edge.
REQ-026 Drain and evaluation in the same cycle: buffer counts as free; new payload loads, out_valid stays 1.
REQ-027 A header arriving during RESP is accepted (RESP -> PAYLOAD directly), giving back-to-back frames no dead cycle.

Reset
REQ-028 reset_n low, asynchronously: state IDLE, expected seq 0, buffer empty, counter 0.
REQ-029 Reset values: ack_nak 00, ack_seq 0, out_valid 0, out_data 0, frame_err 0.
REQ-030 Reset mid-frame discards partial frame and any buffered payload; no response issued.

Structure
REQ-031 Shared package arq_pkg holds ACK/NAK/NONE encodings, header marker 4'hA, FSM state typedef, sequence width 12, data width 16.
REQ-032 Inactivity counter is sub-module arq_rx_timer (inputs clear/enable, output expired); all else inline.

Verification
REQ-033 Reset, frame {A000, 1234, B234}, dn_busy_n=1 -> ack_nak 10, ack_seq 000, out_data 1234 for one transfer, expected 001.
REQ-034 Same frame with checksum B235 -> ack_nak 01, ack_seq 000, out_valid stays 0.
REQ-035 After seq 000 ACKed, resend seq 000 frame -> ack_nak 10, ack_seq 000, no second delivery; seq 005 frame -> NAK ack_seq 001.
REQ-036 dn_busy_n=0, two valid frames seq 0,1 -> first ACK and held on out_data, second NAK ack_seq 001; raise dn_busy_n -> one transfer.
REQ-037 Header A7FF then 17 idle cycles -> frame_err pulse, no ack_nak; header 5000 -> frame_err, stays IDLE.
REQ-038 Expected forced to FFF via 4095 good frames -> seq FFF ACK, expected 000; reset_n low mid-payload -> all outputs zero immediately.
